rf_snapshot_unit: RTL

- Bulk-access master for the multi-cycle CPU's 32x32 register file, used while the CPU is halted (debug, context save/restore).
- DUMP mode: reads registers through the file's asynchronous read port and streams them out on a valid/ready interface.
- LOAD mode: accepts a valid/ready word stream and issues synchronous register writes through the file's write port.
- Sits beside the CPU datapath; top level muxes its rf_* outputs onto the register file while busy=1.

---
 rtl/rf_snapshot_if.sv | 32 +++
 rtl/rf_snapshot_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rf_snapshot_if.sv
// rf_snapshot_if: register-file access port plus the DUMP (out_*) and LOAD (in_*) streams
interface rf_snapshot_if;
    logic [4:0]  rf_rs1;
    logic [31:0] rf_rs1_dout;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_din;
    logic        rf_write_enable;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    modport master (
        output rf_rs1, rf_rd, rf_rd_din, rf_write_enable,
        input  rf_rs1_dout,
        output out_valid, out_data, out_idx, out_last,
        input  out_ready,
        input  in_valid, in_data,
        output in_ready
    );
    modport slave (
        input  rf_rs1, rf_rd, rf_rd_din, rf_write_enable,
        output rf_rs1_dout,
        input  out_valid, out_data, out_idx, out_last,
        output out_ready,
        output in_valid, in_data,
        input  in_ready
    );
endinterface

// File: rtl/rf_snapshot_unit.sv
// rf_snapshot_unit: DUMP/LOAD bulk master for the 32x32 register file; define RF_SNAPSHOT_CHECKSUM_EN for a trailing XOR checksum word
module rf_snapshot_unit #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    output logic         busy,
    output logic         done,
    output logic         load_err,
    rf_snapshot_if.master bus
);
`ifdef RF_SNAPSHOT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, DUMP_RD, DUMP_WAIT, LOAD, CSUM_OUT, CSUM_IN, DONE} state_t;
    localparam logic CSUM = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, DUMP_RD, DUMP_WAIT, LOAD, DONE} state_t;
    localparam logic CSUM = 1'b0;
`endif
    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    state_t      state_q;
    logic [4:0]  idx_q, out_idx_q, rf_rd_q;
    logic [31:0] acc_q, out_data_q, rf_rd_din_q;
    logic        out_valid_q, out_last_q, we_q;
    logic        at_last;
`ifdef RF_SNAPSHOT_CHECKSUM_EN
    logic        load_err_q;
    assign load_err    = load_err_q;
    assign bus.in_ready = (state_q == LOAD) || (state_q == CSUM_IN);
`else
    assign load_err    = 1'b0;
    assign bus.in_ready = state_q == LOAD;
`endif
    assign at_last             = idx_q == LAST;
    assign busy                = state_q != IDLE;
    assign done                = state_q == DONE;
    assign bus.rf_rs1          = idx_q;
    assign bus.rf_rd           = rf_rd_q;
    assign bus.rf_rd_din       = rf_rd_din_q;
    assign bus.rf_write_enable = we_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_idx         = out_idx_q;
    assign bus.out_last        = out_last_q;

    // Transfer sequencer: state, index, checksum and every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            rf_rd_q     <= '0;
            rf_rd_din_q <= '0;
            we_q        <= 1'b0;
`ifdef RF_SNAPSHOT_CHECKSUM_EN
            load_err_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    idx_q   <= FIRST;
                    acc_q   <= '0;
`ifdef RF_SNAPSHOT_CHECKSUM_EN
                    load_err_q <= 1'b0;
`endif
                    state_q <= op ? LOAD : DUMP_RD;
                end
                DUMP_RD: begin
                    out_data_q  <= bus.rf_rs1_dout;
                    out_idx_q   <= idx_q;
                    out_valid_q <= 1'b1;
                    out_last_q  <= at_last & ~CSUM;
                    state_q     <= DUMP_WAIT;
                end
                DUMP_WAIT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    acc_q       <= acc_q ^ out_data_q;
                    if (at_last) begin
`ifdef RF_SNAPSHOT_CHECKSUM_EN
                        state_q <= CSUM_OUT;
`else
                        state_q <= DONE;
`endif
                    end else begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= DUMP_RD;
                    end
                end
                LOAD: if (bus.in_valid) begin
                    rf_rd_q     <= idx_q;
                    rf_rd_din_q <= bus.in_data;
                    we_q        <= idx_q != 5'd0;
                    acc_q       <= acc_q ^ bus.in_data;
                    if (at_last) begin
`ifdef RF_SNAPSHOT_CHECKSUM_EN
                        state_q <= CSUM_IN;
`else
                        state_q <= DONE;
`endif
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
`ifdef RF_SNAPSHOT_CHECKSUM_EN
                CSUM_OUT: if (!out_valid_q) begin
                    out_data_q  <= acc_q;
                    out_idx_q   <= '0;
                    out_last_q  <= 1'b1;
                    out_valid_q <= 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= DONE;
                end
                CSUM_IN: if (bus.in_valid) begin
                    load_err_q <= bus.in_data != acc_q;
                    state_q    <= DONE;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
